pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Watches ID/EX/MEM hazard

---
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 83 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard info from ID/EX/MEM in, pipeline register stall/flush controls out
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem2reg;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       end_of_program;
  logic       pc_hold;
  logic       ifid_stall;
  logic       idex_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_hold;
  logic       memwb_bubble;
  logic       halted;
  logic       mem_timeout_err;
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem2reg, ex_branch_taken,
           mem_req, mem_ready, end_of_program,
    input  pc_hold, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_hold, memwb_bubble,
           halted, mem_timeout_err
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem2reg, ex_branch_taken,
           mem_req, mem_ready, end_of_program,
    output pc_hold, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_hold, memwb_bubble,
           halted, mem_timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, branch squash, memory waits with timeout, and drain/halt
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [8:0] MEMSTALL = 9'b111001100;
  localparam logic [8:0] SQUASH   = 9'b000110000;
  localparam logic [8:0] BUBBLE   = 9'b110010000;
  localparam logic [8:0] HALTED   = 9'b111001110;
  localparam logic [8:0] ERRORED  = 9'b111001101;
  typedef enum logic [2:0] {RUN, MEM_WAIT, DRAIN, HALT, ERROR} state_t;
  state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic from_drain, from_drain_n;
  logic load_use, mem_stall;
  logic [8:0] ctl;
  assign load_use = hz.ex_mem2reg && hz.ex_rd != 5'd0 &&
                    ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
  assign mem_stall = hz.mem_req && !hz.mem_ready;
  assign {hz.pc_hold, hz.ifid_stall, hz.idex_stall, hz.ifid_flush, hz.idex_flush,
          hz.exmem_hold, hz.memwb_bubble, hz.halted, hz.mem_timeout_err} = rst ? 9'd0 : ctl;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      drain_cnt  <= DW'(DRAIN_CYCLES - 1);
      from_drain <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      drain_cnt  <= drain_n;
      from_drain <= from_drain_n;
    end
  end
  always_comb begin
    state_n      = state;
    wait_n       = wait_cnt;
    drain_n      = drain_cnt;
    from_drain_n = from_drain;
    ctl          = '0;
    case (state)
      RUN:
        if (mem_stall) begin
          ctl          = MEMSTALL;
          wait_n       = WW'(1);
          from_drain_n = 1'b0;
          state_n      = MEM_WAIT;
        end else if (hz.ex_branch_taken) ctl = SQUASH;
        else if (load_use) ctl = BUBBLE;
        else if (hz.end_of_program) state_n = DRAIN;
      MEM_WAIT:
        if (hz.mem_ready) begin
          wait_n  = '0;
          state_n = from_drain ? DRAIN : RUN;
        end else begin
          ctl     = MEMSTALL;
          wait_n  = wait_cnt + 1'b1;
          state_n = wait_cnt == WW'(MEM_TIMEOUT) ? ERROR : MEM_WAIT;
        end
      DRAIN:
        if (mem_stall) begin
          ctl          = MEMSTALL;
          wait_n       = WW'(1);
          from_drain_n = 1'b1;
          state_n      = MEM_WAIT;
        end else begin
          ctl     = BUBBLE;
          state_n = drain_cnt == '0 ? HALT : DRAIN;
          drain_n = drain_cnt == '0 ? drain_cnt : drain_cnt - 1'b1;
        end
      HALT:    ctl = HALTED;
      ERROR:   ctl = ERRORED;
      default: state_n = RUN;
    endcase
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard sequencing against hand-computed control patterns
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] IDLE     = 9'b000000000;
  localparam logic [8:0] MEMSTALL = 9'b111001100;
  localparam logic [8:0] SQUASH   = 9'b000110000;
  localparam logic [8:0] BUBBLE   = 9'b110010000;
  localparam logic [8:0] HALTED   = 9'b111001110;
  localparam logic [8:0] ERRORED  = 9'b111001101;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  pipeline_hazard_ctrl_if hz ();
  pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz.slave));
  always #5 clk = ~clk;
  function automatic logic [8:0] outs();
    return {hz.pc_hold, hz.ifid_stall, hz.idex_stall, hz.ifid_flush, hz.idex_flush,
            hz.exmem_hold, hz.memwb_bubble, hz.halted, hz.mem_timeout_err};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_mem2reg = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.end_of_program = 1'b0;
    #1;
  endtask
  task automatic set_load_use();
    hz.ex_mem2reg = 1'b1; hz.ex_rd = 5'd5;
    hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd3;
    hz.id_uses_rs2 = 1'b1; hz.id_rs2 = 5'd5;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    set_load_use();
    hz.mem_req = 1'b1;
    tick();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", outs(), IDLE); end
    rst = 1'b0;
    idle();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL post_reset_idle got=%b exp=%b", outs(), IDLE); end
  endtask
  task automatic test_load_use();
    set_load_use();
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL load_use_rs2 got=%b exp=%b", outs(), BUBBLE); end
    tick();
    idle();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL load_use_release got=%b exp=%b", outs(), IDLE); end
    hz.ex_mem2reg = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_uses_rs1 = 1'b1;
    #1;
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL load_use_rs1 got=%b exp=%b", outs(), BUBBLE); end
    hz.id_uses_rs1 = 1'b0;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL rs1_not_used got=%b exp=%b", outs(), IDLE); end
    hz.id_uses_rs1 = 1'b1; hz.ex_mem2reg = 1'b0;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL not_a_load got=%b exp=%b", outs(), IDLE); end
    tick();
    idle();
  endtask
  task automatic test_x0();
    hz.ex_mem2reg = 1'b1; hz.ex_rd = 5'd0;
    hz.id_uses_rs1 = 1'b1; hz.id_rs1 = 5'd0; hz.id_uses_rs2 = 1'b1; hz.id_rs2 = 5'd0;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL load_x0 got=%b exp=%b", outs(), IDLE); end
    tick();
    idle();
  endtask
  task automatic test_branch();
    set_load_use();
    hz.ex_branch_taken = 1'b1;
    #1;
    checks++; if (outs() !== SQUASH) begin fails++; $display("FAIL branch_over_load_use got=%b exp=%b", outs(), SQUASH); end
    tick();
    idle();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL branch_release got=%b exp=%b", outs(), IDLE); end
  endtask
  task automatic test_mem_wait();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (outs() !== MEMSTALL) begin fails++; $display("FAIL mem_stall_%0d got=%b exp=%b", i, outs(), MEMSTALL); end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL mem_ready_cycle got=%b exp=%b", outs(), IDLE); end
    tick();
    idle();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL mem_back_run got=%b exp=%b", outs(), IDLE); end
    set_load_use();
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL mem_run_load_use got=%b exp=%b", outs(), BUBBLE); end
    tick();
    idle();
  endtask
  task automatic test_timeout();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (outs() !== MEMSTALL) begin fails++; $display("FAIL timeout_wait_%0d got=%b exp=%b", i, outs(), MEMSTALL); end
      tick();
    end
    checks++; if (outs() !== ERRORED) begin fails++; $display("FAIL timeout_error got=%b exp=%b", outs(), ERRORED); end
    hz.mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (outs() !== ERRORED) begin fails++; $display("FAIL error_sticky got=%b exp=%b", outs(), ERRORED); end
    idle();
    do_reset();
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL error_cleared got=%b exp=%b", outs(), IDLE); end
  endtask
  task automatic test_drain();
    hz.end_of_program = 1'b1;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL eop_cycle got=%b exp=%b", outs(), IDLE); end
    tick();
    hz.end_of_program = 1'b0;
    hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL drain_%0d got=%b exp=%b", i, outs(), BUBBLE); end
      tick();
    end
    checks++; if (outs() !== HALTED) begin fails++; $display("FAIL halted got=%b exp=%b", outs(), HALTED); end
    tick();
    checks++; if (outs() !== HALTED) begin fails++; $display("FAIL halt_holds got=%b exp=%b", outs(), HALTED); end
    idle();
    do_reset();
  endtask
  task automatic test_drain_reset();
    hz.end_of_program = 1'b1;
    tick();
    hz.end_of_program = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL mid_drain got=%b exp=%b", outs(), BUBBLE); end
    rst = 1'b1;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL drain_rst_outputs got=%b exp=%b", outs(), IDLE); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL drain_rst_run got=%b exp=%b", outs(), IDLE); end
    set_load_use();
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL drain_rst_load_use got=%b exp=%b", outs(), BUBBLE); end
    tick();
    idle();
  endtask
  task automatic test_drain_mem();
    hz.end_of_program = 1'b1;
    tick();
    hz.end_of_program = 1'b0;
    #1;
    checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL dm_first got=%b exp=%b", outs(), BUBBLE); end
    tick();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (outs() !== MEMSTALL) begin fails++; $display("FAIL dm_stall_%0d got=%b exp=%b", i, outs(), MEMSTALL); end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    checks++; if (outs() !== IDLE) begin fails++; $display("FAIL dm_ready got=%b exp=%b", outs(), IDLE); end
    tick();
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs() !== BUBBLE) begin fails++; $display("FAIL dm_drain_%0d got=%b exp=%b", i, outs(), BUBBLE); end
      tick();
    end
    checks++; if (outs() !== HALTED) begin fails++; $display("FAIL dm_halted got=%b exp=%b", outs(), HALTED); end
    idle();
    do_reset();
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_drain();
    test_drain_reset();
    test_drain_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
